// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
//   Lookup is combinational; a miss refills the whole line over a
//   one-word-per-beat req/ack handshake while stall_ic is held high.
// Parameters: LINES (lines, power of two >= 2), LINE_WORDS (32-bit words
//   per line, power of two >= 2).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pcF      in  32   fetch address, bits [1:0] ignored
//   instrF   out 32   instruction for pcF, valid while stall_ic=0
//   stall_ic out 1    miss or fill in progress
//   mem_req  out 1    memory read request (held through the fill)
//   mem_addr out 32   byte address of the current beat
//   mem_rdata in 32   read data, qualified by mem_ack
//   mem_ack  in  1    beat complete, only honoured while mem_req=1
// Optional: define ICACHE_STATS_EN to add hit_cnt / miss_cnt outputs.
module icache_dm #(
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        stall_ic,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned OB = $clog2(LINE_WORDS);
  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TB = 32 - OB - IB - 2;

  typedef enum logic [1:0] {IDLE, FILL, REFILL_DONE} state_t;

  state_t          state;
  logic [LINES-1:0] valid;
  logic [TB-1:0]   tagArr  [LINES];
  logic [31:0]     dataArr [LINES][LINE_WORDS];

  logic [IB-1:0]   fillIdx;
  logic [TB-1:0]   fillTag;
  logic [OB-1:0]   beat;

  logic [OB-1:0]   offset;
  logic [IB-1:0]   index;
  logic [TB-1:0]   tag;
  logic            hit;
  logic            lastBeat;
  logic            unusedPcBits;

  assign offset       = pcF[OB+1:2];
  assign index        = pcF[OB+IB+1:OB+2];
  assign tag          = pcF[31:OB+IB+2];
  assign unusedPcBits = ^pcF[1:0];

  assign hit      = valid[index] && (tagArr[index] == tag);
  assign lastBeat = (beat == OB'(LINE_WORDS - 1));

  always_comb begin
    instrF   = '0;
    stall_ic = 1'b1;
    if (state == IDLE && hit) begin
      instrF   = dataArr[index][offset];
      stall_ic = 1'b0;
    end
  end

  // Control state; the arrays below are deliberately left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      beat     <= '0;
      fillIdx  <= '0;
      fillTag  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state    <= FILL;
            mem_req  <= 1'b1;
            mem_addr <= {pcF[31:OB+2], {(OB+2){1'b0}}};
            fillIdx  <= index;
            fillTag  <= tag;
            beat     <= '0;
          end
        end
        FILL: begin
          if (mem_ack) begin
            beat     <= beat + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            // Valid is only raised with the final beat so a partial
            // line can never be reported as a hit.
            if (lastBeat) begin
              valid[fillIdx] <= 1'b1;
              mem_req        <= 1'b0;
              state          <= REFILL_DONE;
            end
          end
        end
        REFILL_DONE: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      dataArr[fillIdx][beat] <= mem_rdata;
      if (lastBeat) tagArr[fillIdx] <= fillTag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: self-checking bench for icache_dm (default 8 lines x 4 words).
// Memory returns addr ^ 0xA5A5_0000 for every word.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stall_ic;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_dm #(.LINES(8), .LINE_WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .pcF      (pcF),
    .instrF   (instrF),
    .stall_ic (stall_ic),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K = 32'hA5A5_0000;

  int nVec = 0;
  int nMis = 0;

  // Reference model: which memory block each of the 8 lines holds.
  bit          modelValid [8];
  int unsigned modelTag   [8];
  int unsigned expHits;
  int unsigned expMisses;

  typedef struct {
    logic [31:0] pc;
    logic        expStall;
    logic [31:0] expInstr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelHit(input logic [31:0] pc);
    int unsigned idx = (pc / 16) % 8;
    return modelValid[idx] && (modelTag[idx] == pc / 128);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 8; i++) modelValid[i] = 0;
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic fetchHit(input logic [31:0] pc);
    pcF       = pc;
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    #1;
    check("hit_stall", stall_ic, 1'b0);
    check("hit_instr", instrF, (pc & 32'hFFFF_FFFC) ^ K);
    check("hit_req", mem_req, 1'b0);
    tick();
    expHits++;
  endtask

  // mode: 0 ack every cycle, 1 ack every 3rd cycle, 2 random acks.
  // abortAt >= 0 asserts rst once that many beats have been acked.
  task automatic doFill(input logic [31:0] pc, input int mode, input bit doChange,
                        input logic [31:0] newPc, input int abortAt, output int stallCycles);
    logic [31:0] base;
    int          beat;
    int          cyc;
    bit          ack;
    base        = pc & 32'hFFFF_FFF0;
    stallCycles = 0;
    pcF         = pc;
    mem_ack     = 1'($urandom % 2);
    mem_rdata   = $urandom;
    #1;
    check("miss_stall", stall_ic, 1'b1);
    check("miss_instr", instrF, 32'h0);
    check("miss_req", mem_req, 1'b0);
    stallCycles++;
    expMisses++;
    tick();
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 100) begin
      if (beat == abortAt) begin
        mem_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", stall_ic, 1'b1);
        check("rst_instr", instrF, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        clearModel();
        return;
      end
      if (doChange && beat == 1) pcF = newPc;
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 3 == 2);
        default: ack = 1'($urandom % 2);
      endcase
      mem_ack   = ack;
      mem_rdata = ack ? ((base + 4 * beat) ^ K) : $urandom;
      #1;
      check("fill_req", mem_req, 1'b1);
      check("fill_addr", mem_addr, base + 4 * beat);
      check("fill_stall", stall_ic, 1'b1);
      stallCycles++;
      tick();
      if (ack) beat++;
      cyc++;
    end
    if (beat < 4) check("fill_timeout", beat, 4);
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    #1;
    check("done_req", mem_req, 1'b0);
    check("done_stall", stall_ic, 1'b1);
    stallCycles++;
    tick();
    mem_ack = 1'b0;
    modelValid[(pc / 16) % 8] = 1;
    modelTag[(pc / 16) % 8]   = pc / 128;
  endtask

  task automatic access(input logic [31:0] pc, input int mode, input bit doChange, input logic [31:0] newPc);
    int sc;
    if (modelHit(pc)) fetchHit(pc);
    else doFill(pc, mode, doChange, newPc, -1, sc);
  endtask

  task automatic checkStats();
`ifdef ICACHE_STATS_EN
    #1;
    check("miss_cnt", miss_cnt, expMisses);
    check("hit_cnt", hit_cnt, expHits);
`endif
  endtask

  initial begin
    vec_t        vecs [8];
    int          sc;
    logic [31:0] pc;
    logic [31:0] np;

    vecs[0] = '{32'h0000_0040, 1'b0, 32'hA5A5_0040};
    vecs[1] = '{32'h0000_0044, 1'b0, 32'hA5A5_0044};
    vecs[2] = '{32'h0000_0048, 1'b0, 32'hA5A5_0048};
    vecs[3] = '{32'h0000_004C, 1'b0, 32'hA5A5_004C};
    vecs[4] = '{32'h0000_0047, 1'b0, 32'hA5A5_0044};
    vecs[5] = '{32'h0000_0050, 1'b1, 32'h0};
    vecs[6] = '{32'h0000_00C0, 1'b1, 32'h0};
    vecs[7] = '{32'h0000_1048, 1'b1, 32'h0};

    // Reset state
    rst       = 1'b1;
    pcF       = $urandom;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    clearModel();
    tick();
    check("rst_stall0", stall_ic, 1'b1);
    check("rst_instr0", instrF, 32'h0);
    check("rst_req0", mem_req, 1'b0);
    check("rst_addr0", mem_addr, 32'h0);
    rst = 1'b0;

    // Cold miss
    doFill(32'h40, 0, 0, 32'h0, -1, sc);
    check("cold_stall_cycles", sc, 6);
    fetchHit(32'h40);

    // Table of lookups against the filled line; misses are checked
    // combinationally and never clocked.
    for (int i = 0; i < 8; i++) begin
      pcF     = vecs[i].pc;
      mem_ack = 1'b0;
      #1;
      check("tbl_stall", stall_ic, vecs[i].expStall);
      check("tbl_instr", instrF, vecs[i].expInstr);
      check("tbl_req", mem_req, 1'b0);
      if (!vecs[i].expStall) begin
        tick();
        expHits++;
      end
    end

    // Conflict eviction
    doFill(32'hC0, 0, 0, 32'h0, -1, sc);
    check("evict_stall_cycles", sc, 6);
    fetchHit(32'hC0);
    doFill(32'h40, 0, 0, 32'h0, -1, sc);
    check("evict2_stall_cycles", sc, 6);
    fetchHit(32'h40);
    checkStats();

    // Slow memory, pc moves mid-fill; the original line still completes
    doFill(32'h80, 1, 1, 32'h200, -1, sc);
    doFill(32'h200, 0, 0, 32'h0, -1, sc);
    fetchHit(32'h200);
    access(32'h84, 0, 0, 32'h0);
    fetchHit(32'h88);

    // Reset mid-fill, then a clean refill of the same line
    doFill(32'h104, 0, 0, 32'h0, 2, sc);
    doFill(32'h104, 0, 0, 32'h0, -1, sc);
    check("refill_stall_cycles", sc, 6);
    fetchHit(32'h104);
    fetchHit(32'h100);

    // Randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      pc = ((32'($urandom % 3)) << 7) | ((32'($urandom % 8)) << 4) |
           ((32'($urandom % 4)) << 2) | 32'($urandom % 4);
      np = ((32'($urandom % 3)) << 7) | ((32'($urandom % 8)) << 4);
      access(pc, 2, 1'($urandom % 4 == 0), np);
    end
    checkStats();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
